alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational 16-bit ALU/FSM decoder.
- Same 5-bit alu_code map covers four groups: arithmetic, logic, shift and set/compare.
- Adds WIDTH generalisation, valid/ready flow control with backpressure, a tag passthrough, an illegal-opcode flag and a sticky overflow status bit.
- Sits between the operand/issue logic and the writeback path of the datapath.

---
 rtl/alu_pipe.sv | 192 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand register, then result register.
// Valid/ready flow control with tag passthrough and a sticky overflow bit.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       alu_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             overflow,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       code;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t  s1;
  logic s1_valid;
  logic adv2;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1 <= '{a: A, b: B, code: alu_code, tag: in_tag};
      end
    end
  end

  logic [1:0]       grp;
  logic [2:0]       fn;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic [SW-1:0]    sh;
  logic [SW:0]      sh1;
  logic [WIDTH-1:0] top;
  logic             sla_ovf;
  logic [WIDTH-1:0] sra;
  logic             lt;
  logic             eq;
  logic             sa;
  logic             sb;

  assign grp = s1.code[4:3];
  assign fn  = s1.code[2:0];
  assign sa  = s1.a[MSB];
  assign sb  = s1.b[MSB];

  assign sum = {1'b0, s1.a} + {1'b0, s1.b};
  assign dif = {1'b0, s1.a} - {1'b0, s1.b};
  assign inc = s1.a + WIDTH'(1);
  assign dec = s1.a - WIDTH'(1);

  // SLA keeps sign only if the top s+1 bits of A all match A's sign.
  assign sh      = s1.b[SW-1:0];
  assign sh1     = {1'b0, sh} + {{SW{1'b0}}, 1'b1};
  assign top     = ~({WIDTH{1'b1}} >> sh1);
  assign sla_ovf = |((s1.a ^ {WIDTH{sa}}) & top);
  assign sra     = $signed(s1.a) >>> sh;

  assign lt = $signed(s1.a) < $signed(s1.b);
  assign eq = s1.a == s1.b;

  logic [WIDTH-1:0] c_n;
  logic             ovf_n;
  logic             ill_n;

  always_comb begin
    c_n   = '0;
    ovf_n = 1'b0;
    ill_n = 1'b0;
    unique case (grp)
      2'b00: begin
        unique case (fn)
          3'b000: begin
            c_n   = sum[MSB:0];
            ovf_n = sum[WIDTH];
          end
          3'b001: begin
            c_n   = sum[MSB:0];
            ovf_n = (sa == sb) && (sum[MSB] != sa);
          end
          3'b010: begin
            c_n   = dif[MSB:0];
            ovf_n = dif[WIDTH];
          end
          3'b011: begin
            c_n   = dif[MSB:0];
            ovf_n = (sa != sb) && (dif[MSB] != sa);
          end
          3'b100: begin
            c_n   = inc;
            ovf_n = !sa && inc[MSB];
          end
          3'b101: begin
            c_n   = dec;
            ovf_n = sa && !dec[MSB];
          end
          default: ill_n = 1'b1;
        endcase
      end
      2'b01: begin
        unique case (fn)
          3'b000:  c_n = s1.a & s1.b;
          3'b001:  c_n = s1.a | s1.b;
          3'b010:  c_n = s1.a ^ s1.b;
          3'b100:  c_n = ~s1.a;
          default: ill_n = 1'b1;
        endcase
      end
      2'b10: begin
        unique case (fn)
          3'b000: c_n = s1.a << sh;
          3'b001: c_n = s1.a >> sh;
          3'b010: begin
            c_n   = s1.a << sh;
            ovf_n = sla_ovf;
          end
          3'b011:  c_n = sra;
          default: ill_n = 1'b1;
        endcase
      end
      default: begin
        unique case (fn)
          3'b000:  c_n = WIDTH'(lt || eq);
          3'b001:  c_n = WIDTH'(lt);
          3'b010:  c_n = WIDTH'(!eq);
          3'b011:  c_n = WIDTH'(eq);
          3'b100:  c_n = WIDTH'(!lt);
          3'b101:  c_n = WIDTH'(!(lt || eq));
          default: ill_n = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      C         <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      out_tag   <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        C        <= c_n;
        overflow <= ovf_n;
        illegal  <= ill_n;
        out_tag  <= s1.tag;
      end
    end
  end

  // A set on consumption outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (out_valid && out_ready && overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed plan cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [4:0]  code = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] C;
  logic        overflow;
  logic        illegal;
  logic [3:0]  out_tag;
  logic        sticky_ovf;
  logic        clr_sticky = 1'b0;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_a = '0;
  logic [31:0] w_b = '0;
  logic [4:0]  w_code = '0;
  logic [3:0]  w_in_tag = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_c;
  logic        w_overflow;
  logic        w_illegal;
  logic [3:0]  w_out_tag;
  logic        w_sticky;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .alu_code(code), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .C(C),
    .overflow(overflow), .illegal(illegal), .out_tag(out_tag),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
  );

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .A(w_a), .B(w_b), .alu_code(w_code), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .C(w_c),
    .overflow(w_overflow), .illegal(w_illegal), .out_tag(w_out_tag),
    .sticky_ovf(w_sticky), .clr_sticky(1'b0)
  );

  typedef struct {
    logic [63:0] c;
    logic        ovf;
    logic        ill;
    logic [3:0]  tag;
  } res_t;

  // Signed/unsigned integer arithmetic; range tests replace bit tricks.
  function automatic res_t model(int w, logic [4:0] op,
                                 logic [63:0] a, logic [63:0] b);
    res_t   r;
    longint m, ua, ub, sa, sb, v, mx, mn;
    int     s;
    bit     ok;
    m  = (longint'(1) <<< w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = ua[w-1] ? ua - (m + 1) : ua;
    sb = ub[w-1] ? ub - (m + 1) : ub;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    s  = int'(ub % longint'(w));
    v = 0; ok = 1'b1;
    r.ovf = 1'b0; r.tag = '0;
    case (op)
      5'b00000: begin v = ua + ub; r.ovf = v > m; end
      5'b00001: begin v = sa + sb; r.ovf = v > mx || v < mn; end
      5'b00010: begin v = ua - ub; r.ovf = ua < ub; end
      5'b00011: begin v = sa - sb; r.ovf = v > mx || v < mn; end
      5'b00100: begin v = sa + 1;  r.ovf = v > mx; end
      5'b00101: begin v = sa - 1;  r.ovf = v < mn; end
      5'b01000: v = ua & ub;
      5'b01001: v = ua | ub;
      5'b01010: v = ua ^ ub;
      5'b01100: v = ~ua;
      5'b10000: v = ua << s;
      5'b10001: v = ua >> s;
      5'b10010: begin
        v = sa * (longint'(1) <<< s);
        r.ovf = v > mx || v < mn;
      end
      5'b10011: v = sa >>> s;
      5'b11000: v = longint'(sa <= sb);
      5'b11001: v = longint'(sa < sb);
      5'b11010: v = longint'(sa != sb);
      5'b11011: v = longint'(sa == sb);
      5'b11100: v = longint'(sa >= sb);
      5'b11101: v = longint'(sa > sb);
      default: ok = 1'b0;
    endcase
    r.c   = ok ? 64'(v & m) : 64'd0;
    r.ill = !ok;
    return r;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tg,
                        output logic [15:0] c, output logic ov,
                        output logic il, output logic [3:0] t,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; code = op; in_tag = tg;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    c = C; ov = overflow; il = illegal; t = out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || C !== 16'h0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: valid=%b C=%h ovf=%b need 0", out_valid, C, overflow);
    end
    checks++;
    if (illegal !== 1'b0 || out_tag !== 4'h0 || sticky_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: ill=%b tag=%h sticky=%b need 0",
               illegal, out_tag, sticky_ovf);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b need 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    logic [15:0] c; logic ov, il; logic [3:0] t; int lat;
    run_op(5'b00000, 16'hFFFF, 16'h0001, 4'h3, c, ov, il, t, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL add_latency: got %0d need 2", lat);
    end
    checks++;
    if (c !== 16'h0000 || ov !== 1'b1 || t !== 4'h3) begin
      failures++;
      $display("FAIL add_carry: C=%h ovf=%b tag=%h need 0000/1/3", c, ov, t);
    end
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear: got %b need 0", sticky_ovf);
    end
    run_op(5'b00001, 16'h7FFF, 16'h0001, 4'h4, c, ov, il, t, lat);
    checks++;
    if (c !== 16'h8000 || ov !== 1'b1) begin
      failures++;
      $display("FAIL adds_ovf: C=%h ovf=%b need 8000/1", c, ov);
    end
    @(negedge clk);
    checks++;
    if (sticky_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set: got %b need 1", sticky_ovf);
    end
    run_op(5'b00010, 16'h0003, 16'h0005, 4'h5, c, ov, il, t, lat);
    checks++;
    if (c !== 16'hFFFE || ov !== 1'b1) begin
      failures++;
      $display("FAIL sub_borrow: C=%h ovf=%b need FFFE/1", c, ov);
    end
    run_op(5'b00011, 16'h0003, 16'h0005, 4'h6, c, ov, il, t, lat);
    checks++;
    if (c !== 16'hFFFE || ov !== 1'b0) begin
      failures++;
      $display("FAIL subs: C=%h ovf=%b need FFFE/0", c, ov);
    end
  endtask

  task automatic test_compare();
    logic [15:0] c; logic ov, il; logic [3:0] t; int lat;
    run_op(5'b11001, 16'hFFFF, 16'h0001, 4'h7, c, ov, il, t, lat);
    checks++;
    if (c !== 16'h0001 || ov !== 1'b0 || il !== 1'b0) begin
      failures++;
      $display("FAIL slt: C=%h ovf=%b ill=%b need 0001/0/0", c, ov, il);
    end
    run_op(5'b11011, 16'h1234, 16'h1234, 4'h8, c, ov, il, t, lat);
    checks++;
    if (c !== 16'h0001) begin
      failures++;
      $display("FAIL seq: C=%h need 0001", c);
    end
  endtask

  task automatic test_shift();
    logic [15:0] c; logic ov, il; logic [3:0] t; int lat;
    run_op(5'b10011, 16'h8010, 16'h0004, 4'h1, c, ov, il, t, lat);
    checks++;
    if (c !== 16'hF801 || ov !== 1'b0) begin
      failures++;
      $display("FAIL sra: C=%h ovf=%b need F801/0", c, ov);
    end
    run_op(5'b10001, 16'h8010, 16'h0004, 4'h2, c, ov, il, t, lat);
    checks++;
    if (c !== 16'h0801) begin
      failures++;
      $display("FAIL srl: C=%h need 0801", c);
    end
    run_op(5'b10010, 16'h4000, 16'h0001, 4'h3, c, ov, il, t, lat);
    checks++;
    if (c !== 16'h8000 || ov !== 1'b1) begin
      failures++;
      $display("FAIL sla_ovf: C=%h ovf=%b need 8000/1", c, ov);
    end
    run_op(5'b10000, 16'h0001, 16'h0013, 4'h4, c, ov, il, t, lat);
    checks++;
    if (c !== 16'h0008 || ov !== 1'b0) begin
      failures++;
      $display("FAIL sll_amt: C=%h ovf=%b need 0008/0", c, ov);
    end
  endtask

  task automatic test_illegal_sticky();
    logic [15:0] c; logic ov, il; logic [3:0] t; int lat;
    run_op(5'b01011, 16'hABCD, 16'h1234, 4'hA, c, ov, il, t, lat);
    checks++;
    if (il !== 1'b1 || c !== 16'h0 || ov !== 1'b0 || t !== 4'hA) begin
      failures++;
      $display("FAIL illegal_01011: ill=%b C=%h ovf=%b tag=%h need 1/0/0/A",
               il, c, ov, t);
    end
    run_op(5'b00111, 16'hFFFF, 16'hFFFF, 4'hB, c, ov, il, t, lat);
    checks++;
    if (il !== 1'b1 || c !== 16'h0 || ov !== 1'b0 || t !== 4'hB) begin
      failures++;
      $display("FAIL illegal_00111: ill=%b C=%h ovf=%b tag=%h need 1/0/0/B",
               il, c, ov, t);
    end
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    run_op(5'b00000, 16'h8000, 16'h8000, 4'hC, c, ov, il, t, lat);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set_wins: got %b need 1", sticky_ovf);
    end
  endtask

  task automatic test_back_to_back();
    res_t        q[$];
    res_t        e;
    logic [4:0]  ops[4];
    logic [15:0] av[4];
    logic [15:0] bv[4];
    logic [15:0] held_c;
    int          idx = 0;
    int          got = 0;
    int          cyc = 0;
    int          extra = 0;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 5'b00000 + 5'(i);
      av[i] = rnd16();
      bv[i] = rnd16();
    end
    held_c = '0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      in_valid = idx < 4;
      if (idx < 4) begin
        A = av[idx]; B = bv[idx]; code = ops[idx]; in_tag = 4'(idx + 1);
      end
      out_ready = cyc >= 5;
      #1;
      if (cyc == 2) begin
        held_c = C;
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready: accepted=%0d in_ready=%b need 2/0",
                   idx, in_ready);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'h1 || C !== held_c) begin
          failures++;
          $display("FAIL bp_hold: valid=%b tag=%h C=%h need 1/1/%h",
                   out_valid, out_tag, C, held_c);
        end
      end
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++;
        if (out_tag !== e.tag || C !== e.c[15:0] || overflow !== e.ovf) begin
          failures++;
          $display("FAIL bp_order: tag=%h C=%h ovf=%b need %h/%h/%b",
                   out_tag, C, overflow, e.tag, e.c[15:0], e.ovf);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e = model(16, ops[idx], 64'(av[idx]), 64'(bv[idx]));
        e.tag = 4'(idx + 1);
        q.push_back(e);
        idx++;
      end
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL bp_count: got %0d results need 4", got);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      #1;
      if (out_valid) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL bp_dup: %0d extra results need 0", extra);
    end
  endtask

  task automatic test_random();
    res_t        q[$];
    res_t        e;
    logic        stalled = 1'b0;
    logic [21:0] last = '0;
    int          bad = 0;
    int          n = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      in_valid = cyc < 450 && $urandom_range(0, 3) != 0;
      A = rnd16(); B = rnd16();
      code = ($urandom_range(0, 4) == 0) ? 5'($urandom)
           : 5'(($urandom_range(0, 3) << 3) | $urandom_range(0, 5));
      in_tag = 4'($urandom);
      out_ready = cyc >= 450 || $urandom_range(0, 2) != 0;
      #1;
      if (stalled) begin
        checks++;
        if ({out_valid, C, overflow, illegal, out_tag} !== {1'b1, last}) begin
          failures++;
          $display("FAIL rnd_hold: C=%h tag=%h moved while stalled", C, out_tag);
        end
      end
      stalled = out_valid && !out_ready;
      last = {C, overflow, illegal, out_tag};
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious: result tag=%h with nothing issued", out_tag);
        end else begin
          e = q.pop_front();
          n++;
          if ({C, overflow, illegal, out_tag} !==
              {e.c[15:0], e.ovf, e.ill, e.tag}) begin
            failures++;
            bad++;
            if (bad < 10)
              $display("FAIL rnd_result: C=%h ovf=%b ill=%b tag=%h need %h/%b/%b/%h",
                       C, overflow, illegal, out_tag,
                       e.c[15:0], e.ovf, e.ill, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(16, code, 64'(A), 64'(B));
        e.tag = in_tag;
        q.push_back(e);
      end
    end
    checks++;
    if (q.size() != 0 || n < 100) begin
      failures++;
      $display("FAIL rnd_drain: %0d left, %0d done need 0/>=100", q.size(), n);
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] c; logic ov, il; logic [3:0] t; int lat;
    int seen = 0;
    run_op(5'b00000, 16'hFFFF, 16'h0002, 4'h1, c, ov, il, t, lat);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; A = 16'h1111; B = 16'h2222; code = 5'b00000; in_tag = 4'h2;
    @(negedge clk);
    in_tag = 4'h3;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sticky_ovf !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup: valid=%b sticky=%b need 1/1", out_valid, sticky_ovf);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || C !== 16'h0 || sticky_ovf !== 1'b0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_flush: valid=%b C=%h sticky=%b in_ready=%b need 0/0/0/1",
               out_valid, C, sticky_ovf, in_ready);
    end
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_ignore_in: %0d results after reset need 0", seen);
    end
  endtask

  task automatic test_width32();
    res_t        e;
    logic [31:0] ra[4];
    logic [31:0] rb[4];
    logic [4:0]  rc[4];
    int          lat;
    ra = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'($urandom), 32'h80000001};
    rb = '{32'h00000001, 32'h00000001, 32'($urandom), 32'h00000005};
    rc = '{5'b00000, 5'b00001, 5'b00011, 5'b10010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_in_valid = 1'b1; w_a = ra[i]; w_b = rb[i]; w_code = rc[i];
      w_in_tag = 4'(i);
      @(negedge clk);
      w_in_valid = 1'b0;
      lat = 1;
      while (!w_out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      e = model(32, rc[i], 64'(ra[i]), 64'(rb[i]));
      checks++;
      if (lat !== 2 || w_c !== e.c[31:0] || w_overflow !== e.ovf ||
          w_out_tag !== 4'(i)) begin
        failures++;
        $display("FAIL w32_op%0d: lat=%0d C=%h ovf=%b tag=%h need 2/%h/%b/%h",
                 i, lat, w_c, w_overflow, w_out_tag, e.c[31:0], e.ovf, 4'(i));
      end
    end
    checks++;
    if (w_sticky !== 1'b1) begin
      failures++;
      $display("FAIL w32_sticky: got %b need 1", w_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_illegal_sticky();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_width32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
